// File: rtl/digdug_hiscore_xfer_pkg.sv
// Shared types for the Dig Dug hiscore transfer engine.
// The CSUM state exists only when HISCORE_CHECKSUM_EN is defined.
package digdug_hiscore_xfer_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned LEN_W  = 11;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [LEN_W-1:0]  len_t;

  localparam logic OP_DUMP    = 1'b0;
  localparam logic OP_RESTORE = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    SETUP,
    RD_ADDR,
    RD_WAIT,
    RD_OUT,
    WR_IN,
    WR_STB,
`ifdef HISCORE_CHECKSUM_EN
    CSUM,
`endif
    FINISH
  } state_t;

endpackage

// File: rtl/digdug_hiscore_xfer.sv
// Moves hiscore bytes between a host stream and the core's hiscore RAM port.
// Optional trailing checksum byte enabled by HISCORE_CHECKSUM_EN.
module digdug_hiscore_xfer
  import digdug_hiscore_xfer_pkg::*;
#(
  parameter int unsigned ACC_SETUP = 2,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic              MCLK,
  input  logic              RESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_OP,
  input  logic [ADDR_W-1:0] CMD_BASE,
  input  logic [LEN_W-1:0]  CMD_LEN,
  input  logic              IN_VALID,
  input  logic [7:0]        IN_DATA,
  output logic              IN_READY,
  output logic              OUT_VALID,
  output logic [7:0]        OUT_DATA,
  input  logic              OUT_READY,
  output logic [ADDR_W-1:0] hs_address,
  output logic [7:0]        hs_data_in,
  output logic              hs_write,
  output logic              hs_access,
  input  logic [7:0]        hs_data_out,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam logic [15:0] SETUP_LAST = 16'((ACC_SETUP > 0) ? ACC_SETUP - 1 : 0);
  localparam logic [15:0] WAIT_LAST  = 16'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  state_t      state;
  logic        op;
  addr_t       base;
  len_t        len;
  len_t        idx;
  logic [15:0] cnt;

`ifdef HISCORE_CHECKSUM_EN
  localparam state_t TAIL = CSUM;
  logic [7:0] sum;
  logic       err_q;
  assign ERR = err_q;
`else
  localparam state_t TAIL = FINISH;
  assign ERR = 1'b0;
`endif

  assign CMD_READY = (state == IDLE);
  assign BUSY      = (state != IDLE);
  assign hs_access = (state != IDLE);
  assign DONE      = (state == FINISH);
`ifdef HISCORE_CHECKSUM_EN
  assign IN_READY  = (state == WR_IN) || ((state == CSUM) && (op == OP_RESTORE));
`else
  assign IN_READY  = (state == WR_IN);
`endif

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      op         <= OP_DUMP;
      base       <= '0;
      len        <= '0;
      idx        <= '0;
      cnt        <= '0;
      hs_address <= '0;
      hs_data_in <= '0;
      hs_write   <= 1'b0;
      OUT_VALID  <= 1'b0;
      OUT_DATA   <= '0;
`ifdef HISCORE_CHECKSUM_EN
      sum        <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (CMD_VALID) begin
          op    <= CMD_OP;
          base  <= CMD_BASE;
          len   <= CMD_LEN;
          idx   <= '0;
          cnt   <= '0;
          state <= SETUP;
`ifdef HISCORE_CHECKSUM_EN
          sum   <= '0;
          err_q <= 1'b0;
`endif
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt        <= '0;
            hs_address <= base;
            state      <= (op == OP_RESTORE) ? WR_IN : RD_ADDR;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RD_ADDR: begin
          cnt   <= '0;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (cnt == WAIT_LAST) begin
            cnt       <= '0;
            OUT_DATA  <= hs_data_out;
            OUT_VALID <= 1'b1;
`ifdef HISCORE_CHECKSUM_EN
            sum       <= sum + hs_data_out;
`endif
            state     <= RD_OUT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RD_OUT: if (OUT_READY) begin
          OUT_VALID <= 1'b0;
          if (idx == len) begin
            state <= TAIL;
`ifdef HISCORE_CHECKSUM_EN
            // Checksum byte is presented straight after the last data byte.
            OUT_VALID <= 1'b1;
            OUT_DATA  <= sum;
`endif
          end else begin
            idx        <= idx + 11'd1;
            hs_address <= base + idx + 11'd1;
            state      <= RD_ADDR;
          end
        end
        WR_IN: if (IN_VALID) begin
          hs_data_in <= IN_DATA;
          hs_write   <= 1'b1;
`ifdef HISCORE_CHECKSUM_EN
          sum        <= sum + IN_DATA;
`endif
          state      <= WR_STB;
        end
        WR_STB: begin
          hs_write <= 1'b0;
          if (idx == len) begin
            state <= TAIL;
          end else begin
            idx        <= idx + 11'd1;
            hs_address <= base + idx + 11'd1;
            state      <= WR_IN;
          end
        end
`ifdef HISCORE_CHECKSUM_EN
        CSUM: begin
          if (op == OP_DUMP) begin
            if (OUT_READY) begin
              OUT_VALID <= 1'b0;
              state     <= FINISH;
            end
          end else if (IN_VALID) begin
            if (IN_DATA != sum) err_q <= 1'b1;
            state <= FINISH;
          end
        end
`endif
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digdug_hiscore_xfer.sv
// Self-checking bench for digdug_hiscore_xfer; honours HISCORE_CHECKSUM_EN.
module tb_digdug_hiscore_xfer;

  localparam int unsigned ACC_SETUP = 2;
  localparam int unsigned RD_LAT    = 2;

  logic        MCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CMD_VALID = 1'b0, CMD_READY, CMD_OP = 1'b0;
  logic [10:0] CMD_BASE = '0, CMD_LEN = '0;
  logic        IN_VALID = 1'b0, IN_READY;
  logic [7:0]  IN_DATA = '0;
  logic        OUT_VALID, OUT_READY = 1'b0;
  logic [7:0]  OUT_DATA;
  logic [10:0] hs_address;
  logic [7:0]  hs_data_in, hs_data_out;
  logic        hs_write, hs_access, BUSY, DONE, ERR;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dcnt;
  logic [10:0] lr;
  logic [7:0]  in_bytes[$];
  logic [7:0]  core_mem[2048];
  logic [7:0]  rd_pipe[RD_LAT];

  digdug_hiscore_xfer #(.ACC_SETUP(ACC_SETUP), .RD_LAT(RD_LAT)) dut (
    .MCLK(MCLK), .RESET(RESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_BASE(CMD_BASE), .CMD_LEN(CMD_LEN),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
    .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_READY(OUT_READY),
    .hs_address(hs_address), .hs_data_in(hs_data_in), .hs_write(hs_write),
    .hs_access(hs_access), .hs_data_out(hs_data_out),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #10 MCLK = ~MCLK;

  // Core RAM read port with RD_LAT register stages.
  always @(posedge MCLK) begin
    rd_pipe[0] <= core_mem[hs_address];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign hs_data_out = rd_pipe[RD_LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge MCLK);
    cyc++;
  endtask

  // Random data bytes, plus the correct checksum byte when that feature is built in.
  task automatic build_in(input logic [10:0] len);
    logic [7:0] s;
    s = '0;
    in_bytes.delete();
    for (int i = 0; i <= int'(len); i++) begin
      in_bytes.push_back(8'($urandom));
      s += in_bytes[i];
    end
`ifdef HISCORE_CHECKSUM_EN
    in_bytes.push_back(s);
`endif
  endtask

  task automatic do_dump(input logic [10:0] base, input logic [10:0] len, input bit stall,
                         input bit spam, input bit timing, input bit rnd);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] sum, sdata;
    int done_cnt, wr_seen, busy_bad, budget, acc_c, addr_c, ov_c, a;
    bit fin, sprev;
    sum = '0; sdata = '0; done_cnt = 0; wr_seen = 0; busy_bad = 0;
    acc_c = -1; addr_c = -1; ov_c = -1; fin = 0; sprev = 0;
    for (int i = 0; i <= int'(len); i++) begin
      a = (int'(base) + i) % 2048;
      if (rnd) core_mem[a] = 8'($urandom);
      exp_q.push_back(core_mem[a]);
      sum += core_mem[a];
    end
`ifdef HISCORE_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
    budget = (int'(len) + 3) * 24 + 64;
    CMD_OP = 1'b0; CMD_BASE = base; CMD_LEN = len; CMD_VALID = 1'b1;
    OUT_READY = !stall;
    for (int t = 0; t < budget; t++) begin
      tick();
      if (acc_c < 0 && hs_access === 1'b1) acc_c = cyc;
      if (acc_c >= 0 && addr_c < 0 && hs_address === base) addr_c = cyc;
      if (ov_c < 0 && OUT_VALID === 1'b1) ov_c = cyc;
      if (DONE === 1'b1) done_cnt++;
      if (hs_write === 1'b1) wr_seen++;
      if (BUSY !== ~CMD_READY || hs_access !== BUSY) busy_bad++;
      if (sprev) begin
        chk("hold_valid", 32'(OUT_VALID), 32'd1);
        chk("hold_data", 32'(OUT_DATA), 32'(sdata));
      end
      if (done_cnt > 0 && CMD_READY === 1'b1) begin
        fin = 1; CMD_VALID = 1'b0;
        break;
      end
      CMD_VALID = spam;
      if (spam) begin CMD_OP = 1'b1; CMD_BASE = 11'($urandom); end
      OUT_READY = stall ? (((cyc / 3) % 2) == 1) : 1'b1;
      sprev = (OUT_VALID === 1'b1) && !OUT_READY;
      sdata = OUT_DATA;
      if (OUT_VALID === 1'b1 && OUT_READY) got_q.push_back(OUT_DATA);
    end
    CMD_VALID = 1'b0;
    chk("dump_finished", 32'(fin), 32'd1);
    chk("dump_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk("dump_byte", 32'(got_q[i]), 32'(exp_q[i]));
    chk("dump_done_pulses", 32'(done_cnt), 32'd1);
    chk("dump_no_write", 32'(wr_seen), 32'd0);
    chk("dump_busy_flags", 32'(busy_bad), 32'd0);
    chk("dump_err", 32'(ERR), 32'd0);
    if (timing) begin
      chk("setup_to_addr", 32'(addr_c - acc_c), 32'(ACC_SETUP));
      chk("addr_to_valid", 32'(ov_c - addr_c), 32'(RD_LAT + 1));
    end
  endtask

  task automatic do_restore(input logic [10:0] base, input logic [10:0] len, input bit stall,
                            input int stop_writes);
    logic [10:0] w_addr[$];
    logic [7:0]  w_data[$];
    logic [7:0]  sum;
    logic        exp_err;
    int done_cnt, k, budget;
    bit fin;
    done_cnt = 0; k = 0; fin = 0; sum = '0; exp_err = 1'b0;
    for (int i = 0; i <= int'(len); i++) sum += in_bytes[i];
`ifdef HISCORE_CHECKSUM_EN
    exp_err = (in_bytes[int'(len) + 1] != sum);
`endif
    budget = (int'(len) + 3) * 24 + 64;
    CMD_OP = 1'b1; CMD_BASE = base; CMD_LEN = len; CMD_VALID = 1'b1; IN_VALID = 1'b0;
    for (int t = 0; t < budget; t++) begin
      tick();
      CMD_VALID = 1'b0;
      if (hs_write === 1'b1) begin
        w_addr.push_back(hs_address);
        w_data.push_back(hs_data_in);
      end
      if (DONE === 1'b1) done_cnt++;
      if (stop_writes > 0 && w_addr.size() >= stop_writes) begin fin = 1; break; end
      if (done_cnt > 0 && CMD_READY === 1'b1) begin fin = 1; break; end
      IN_VALID = (k < in_bytes.size()) && (!stall || ($urandom_range(0, 1) == 1));
      IN_DATA  = IN_VALID ? in_bytes[k] : 8'($urandom);
      if (IN_READY === 1'b1 && IN_VALID) k++;
    end
    IN_VALID = 1'b0;
    chk("restore_finished", 32'(fin), 32'd1);
    if (stop_writes == 0) begin
      chk("restore_writes", 32'(w_addr.size()), 32'(int'(len) + 1));
      for (int i = 0; i < w_addr.size() && i <= int'(len); i++) begin
        chk("restore_addr", 32'(w_addr[i]), 32'((int'(base) + i) % 2048));
        chk("restore_data", 32'(w_data[i]), 32'(in_bytes[i]));
      end
      chk("restore_consumed", 32'(k), 32'(in_bytes.size()));
      chk("restore_done_pulses", 32'(done_cnt), 32'd1);
      chk("restore_err", 32'(ERR), 32'(exp_err));
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_cmd_ready", 32'(CMD_READY), 32'd1);
    chk("reset_busy", 32'(BUSY), 32'd0);
    chk("reset_access", 32'(hs_access), 32'd0);
    chk("reset_write", 32'(hs_write), 32'd0);
    chk("reset_out_valid", 32'(OUT_VALID), 32'd0);
    chk("reset_out_data", 32'(OUT_DATA), 32'd0);
    chk("reset_in_ready", 32'(IN_READY), 32'd0);
    chk("reset_addr", 32'(hs_address), 32'd0);
    chk("reset_wdata", 32'(hs_data_in), 32'd0);
    chk("reset_done", 32'(DONE), 32'd0);
    chk("reset_err", 32'(ERR), 32'd0);
    RESET = 1'b0;
    tick();

    core_mem[11'h100] = 8'h11; core_mem[11'h101] = 8'h22;
    core_mem[11'h102] = 8'h33; core_mem[11'h103] = 8'h44;
    do_dump(11'h100, 11'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    do_dump(11'h7FD, 11'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    do_dump(11'h3A5, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    in_bytes.delete();
    in_bytes.push_back(8'hA1); in_bytes.push_back(8'hB2); in_bytes.push_back(8'hC3);
`ifdef HISCORE_CHECKSUM_EN
    in_bytes.push_back(8'h16);
`endif
    do_restore(11'h7FE, 11'd2, 1'b0, 0);
    build_in(11'd0);
    do_restore(11'h000, 11'd0, 1'b1, 0);

    // Reset lands while the first of four writes is being strobed.
    build_in(11'd3);
    do_restore(11'h123, 11'd3, 1'b0, 1);
    RESET = 1'b1;
    #1;
    chk("async_access", 32'(hs_access), 32'd0);
    chk("async_write", 32'(hs_write), 32'd0);
    chk("async_cmd_ready", 32'(CMD_READY), 32'd1);
    dcnt = 0;
    repeat (3) begin tick(); if (DONE === 1'b1) dcnt++; end
    RESET = 1'b0;
    repeat (3) begin tick(); if (DONE === 1'b1) dcnt++; end
    chk("reset_no_done", 32'(dcnt), 32'd0);
    build_in(11'd4);
    do_restore(11'h200, 11'd4, 1'b1, 0);

`ifdef HISCORE_CHECKSUM_EN
    in_bytes.delete();
    in_bytes.push_back(8'h01); in_bytes.push_back(8'h02); in_bytes.push_back(8'h04);
    do_restore(11'h050, 11'd1, 1'b0, 0);
    chk("csum_err_sticky", 32'(ERR), 32'd1);
    in_bytes.delete();
    in_bytes.push_back(8'h01); in_bytes.push_back(8'h02); in_bytes.push_back(8'h03);
    do_restore(11'h050, 11'd1, 1'b0, 0);
`endif

    for (int r = 0; r < 6; r++) begin
      lr = 11'($urandom_range(0, 12));
      if ($urandom_range(0, 1) == 1) begin
        do_dump(11'($urandom), lr, bit'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
      end else begin
        build_in(lr);
        do_restore(11'($urandom), lr, bit'($urandom_range(0, 1)), 0);
      end
    end

    do_dump(11'h005, 11'h7FF, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digdug_hiscore_xfer.md
DIGDUG_HISCORE_XFER -- requirements
Module: digdug_hiscore_xfer

Interface
REQ-001 SHALL have parameter ACC_SETUP, default 2, giving the cycles hs_access is held before the first memory access.
REQ-002 SHALL have parameter RD_LAT, default 1, giving the cycles from hs_address valid to hs_data_out valid.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: MCLK  in  1  master clock (48 MHz); RESET  in  1  asynchronous active-high reset.
REQ-004 CMD_VALID  in  1  command offered; CMD_READY  out  1  command accepted when both high.
REQ-005 CMD_OP  in  1  0 = dump (memory to host), 1 = restore (host to memory).
REQ-006 CMD_BASE  in  11  start address; CMD_LEN  in  11  byte count minus 1.
REQ-007 IN_VALID  in  1, IN_DATA  in  8, IN_READY  out  1  restore byte stream.
REQ-008 OUT_VALID  out  1, OUT_DATA  out  8, OUT_READY  in  1  dump byte stream.
REQ-009 hs_address  out  11, hs_data_in  out  8, hs_write  out  1, hs_access  out  1  drive the core's hiscore port.
REQ-010 hs_data_out  in  8  read data from the core's hiscore port.
REQ-011 BUSY  out  1  transfer active; DONE  out  1  one-cycle end pulse; ERR  out  1  sticky checksum error.

Function
REQ-012 SHALL use the states IDLE, SETUP, RD_ADDR, RD_WAIT, RD_OUT, WR_IN, WR_STB, CSUM and FINISH.
REQ-013 IDLE: CMD_READY=1; on CMD_VALID, latch OP/BASE/LEN, clear ERR, go to SETUP next cycle.
REQ-014 SETUP: hs_access=1 for exactly ACC_SETUP cycles, no strobes, then RD_ADDR (dump) or WR_IN (restore).
REQ-015 hs_access SHALL stay 1 from SETUP entry through FINISH inclusive, and be 0 in IDLE.
REQ-016 Dump: RD_ADDR drives the address for 1 cycle; RD_WAIT lasts RD_LAT cycles; RD_OUT captures hs_data_out into OUT_DATA and raises OUT_VALID.
REQ-017 OUT_VALID/OUT_DATA SHALL stay stable until OUT_READY=1; on handshake, advance to the next address or end.
REQ-018 Restore: WR_IN holds IN_READY=1; on IN_VALID, latch IN_DATA into hs_data_in and go to WR_STB.
REQ-019 WR_STB: hs_write=1 for exactly 1 cycle with hs_address/hs_data_in stable; no write is issued without a handshaken byte.
REQ-020 Address SHALL be CMD_BASE plus index, modulo 2048 (0x7FF+1 wraps to 0x000).
REQ-021 Transfer length SHALL be CMD_LEN+1 bytes (0 → 1 byte, 0x7FF → 2048 bytes); an 11-bit index terminates after the last byte.
REQ-022 FINISH lasts 1 cycle with DONE=1, then IDLE; BUSY=1 in every state except IDLE.
REQ-023 CMD_VALID while BUSY SHALL be ignored (CMD_READY=0); no queuing.
REQ-024 Stalled streams (OUT_READY=0 or IN_VALID=0) SHALL hold state indefinitely, with hs_access kept high.

Reset
REQ-025 RESET SHALL asynchronously force IDLE and drive all outputs to 0 except CMD_READY, which is 1.
REQ-026 RESET mid-transfer SHALL deassert hs_write and hs_access immediately, drop the partial transfer, and emit no DONE.

Configuration
REQ-027 With HISCORE_CHECKSUM_EN defined, an 8-bit modulo-256 sum of all transferred data bytes SHALL be processed in CSUM, after the last byte and before FINISH.
REQ-028 Dump with HISCORE_CHECKSUM_EN: CSUM emits the sum as one extra OUT byte.
REQ-029 Restore with HISCORE_CHECKSUM_EN: CSUM consumes one extra IN byte; if it differs from the sum, ERR=1 until the next accepted command (memory already written is kept).
REQ-030 Without HISCORE_CHECKSUM_EN: no CSUM state, no sum logic, and ERR is tied to 0.

Structure
REQ-031 A shared package SHALL hold the state enum, the 11-bit address/length widths and the op encodings DUMP=0 / RESTORE=1.
REQ-032 Single module; no sub-module, since the sequencer and datapath are too tightly coupled to split usefully.

Verification
REQ-033 Dump: BASE=0x100, LEN=3, memory 11,22,33,44, OUT_READY=1 -> OUT bytes 11,22,33,44, reads at 0x100-0x103, one DONE pulse.
REQ-034 Restore: BASE=0x7FE, LEN=2, IN bytes A1,B2,C3 -> writes at 0x7FE, 0x7FF, 0x000, each with one hs_write pulse.
REQ-035 Backpressure: dump with OUT_READY toggling every 3 cycles -> no byte lost or duplicated, OUT_DATA stable while stalled.
REQ-036 Reset mid-restore after 1 of 4 bytes -> hs_access=0 asynchronously, no DONE, the next command runs normally.
REQ-037 Timing: ACC_SETUP=2, RD_LAT=2 -> first access 2 cycles after hs_access rises, capture 2 cycles after address.
REQ-038 HISCORE_CHECKSUM_EN restore: bytes 01,02, then checksum 04 (expected 03) -> ERR=1 and DONE; with checksum 03 -> ERR=0.
